semaforo_multivia: RTL
======================

SEMAFORO_MULTIVIA -- requirements
Module: semaforo_multivia

Interface
REQ-001 SHALL have parameter N_VIAS, default 2, number of approaches (legal range 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000, clk cycles per timing tick (legal range ≥1).
REQ-003 SHALL have parameters T_VERDE 20, T_AMARILLO 4, T_TODO_ROJO 2, T_PEATON 10: phase lengths in ticks (legal range 1..255).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port enable  input  1  run when 1; freeze when 0.
REQ-007 SHALL have port sensor  input  N_VIAS  vehicle-present request per approach.
REQ-008 SHALL have port paso  input  N_VIAS  pedestrian button per approach.
REQ-009 SHALL have ports verde, amarillo, rojo  output  N_VIAS each  lamp drives per approach.
REQ-010 SHALL have port peaton_ok  output  1  pedestrian walk indication.
REQ-011 SHALL have port cuenta  output  8  ticks remaining in current phase.
REQ-012 SHALL have port fase  output  max(1,$clog2(N_VIAS))  index of approach currently owning right-of-way.

Function
REQ-013 SHALL implement states VERDE, AMARILLO, TODO_ROJO, PEATON.
REQ-014 SHALL pulse an internal tick for one cycle when the prescaler, counting 0..TICK_DIV-1 while enable=1, reaches TICK_DIV-1, then wrap to 0.
REQ-015 SHALL load cuenta with the phase length on phase entry, decrement on each tick, and end the phase on the tick where cuenta==1 (phase lasts exactly T ticks).
REQ-016 SHALL drive, in VERDE: verde[fase]=1, rojo=1 on all other approaches; in AMARILLO: amarillo[fase]=1, rojo elsewhere; in TODO_ROJO and PEATON: rojo all ones; peaton_ok=1 only in PEATON; lamps one-hot per approach at all times.
REQ-017 SHALL latch demanda[i] when sensor[i]=1 and clear it on entry to VERDE of approach i; clear wins over simultaneous set.
REQ-018 SHALL latch a single ped_pend flag when any paso bit is 1 and clear it on entry to PEATON; clear wins over simultaneous set.
REQ-019 At VERDE end: if no demanda on other approaches and ped_pend=0, SHALL reload T_VERDE and stay in VERDE (rest-on-green); else go to AMARILLO.
REQ-020 AMARILLO end SHALL go to TODO_ROJO.
REQ-021 TODO_ROJO end SHALL go to PEATON if ped_pend=1, else to VERDE of the next approach.
REQ-022 PEATON end SHALL go to VERDE of the next approach.
REQ-023 Next approach SHALL be the first index after fase (round-robin, wrapping N_VIAS-1→0) with demanda set; if none, (fase+1) mod N_VIAS; fase updates on VERDE entry only.
REQ-024 With enable=0 SHALL hold state, prescaler, cuenta and outputs; request latching (REQ-017/018) SHALL continue.

Reset
REQ-025 On rst=1 at a clock edge, regardless of enable or state, SHALL set state=TODO_ROJO, fase=N_VIAS-1, cuenta=T_TODO_ROJO, prescaler=0, demanda=0, ped_pend=0, rojo=all ones, verde=0, amarillo=0, peaton_ok=0.
REQ-026 First green after reset SHALL be approach 0 when no demand exists.

Verification (N_VIAS=2, TICK_DIV=1, T_VERDE=5, T_AMARILLO=2, T_TODO_ROJO=1, T_PEATON=3)
REQ-027 Reset then enable=1, no inputs -> rojo=11, cuenta=1 for 1 cycle, then verde=01, fase=0, cuenta 5,4,3,2,1 repeating indefinitely.
REQ-028 sensor[1] pulsed 1 cycle during approach-0 green -> at expiry amarillo=01 for 2 cycles, rojo=11 for 1, then verde=10, fase=1 for 5 cycles.
REQ-029 paso[0] pulsed 1 cycle during green -> after yellow and all-red, peaton_ok=1 with rojo=11 for 3 cycles, then verde of next approach; ped_pend cleared.
REQ-030 enable=0 for 10 cycles mid-green at cuenta=3 -> verde and cuenta=3 unchanged for 10 cycles, countdown resumes at 2 after enable=1.
REQ-031 rst=1 one cycle during AMARILLO -> next edge rojo=11, amarillo=00, cuenta=1, demanda and ped_pend cleared.
REQ-032 N_VIAS=4, sensors 2 and 3 held during approach-0 green -> green order 0,2,3, with 1 skipped.

Source files
------------

// File: rtl/semaforo_multivia.sv
// Multi-approach traffic light controller: round-robin green with demand skipping,
// rest-on-green, optional pedestrian phase after the all-red clearance.
module semaforo_multivia #(
  parameter int N_VIAS      = 2,
  parameter int TICK_DIV    = 1000,
  parameter int T_VERDE     = 20,
  parameter int T_AMARILLO  = 4,
  parameter int T_TODO_ROJO = 2,
  parameter int T_PEATON    = 10,
  localparam int FW = (N_VIAS > 1) ? $clog2(N_VIAS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_VIAS-1:0] sensor,
  input  logic [N_VIAS-1:0] paso,
  output logic [N_VIAS-1:0] verde,
  output logic [N_VIAS-1:0] amarillo,
  output logic [N_VIAS-1:0] rojo,
  output logic              peaton_ok,
  output logic [7:0]        cuenta,
  output logic [FW-1:0]     fase
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {VERDE, AMARILLO, TODO_ROJO, PEATON} estado_t;

  estado_t           estado_q, estado_d;
  logic [FW-1:0]     fase_q, fase_d, siguiente;
  logic [7:0]        cuenta_q, cuenta_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [N_VIAS-1:0] demanda_q, demanda_d;
  logic              ped_pend_q, ped_pend_d;
  logic [N_VIAS-1:0] verde_q, verde_d, amarillo_q, amarillo_d, rojo_q, rojo_d;
  logic              peaton_q, peaton_d;
  logic              tick, otras_dem, entra_verde, entra_peaton;
  logic [2*N_VIAS-1:0] rot;
  int                sig_i;

  assign tick      = enable && (presc_q == PW'(TICK_DIV - 1));
  assign otras_dem = |(demanda_q & ~(N_VIAS'(1) << fase_q));

  // rot[k] holds demanda of approach (fase+1+k) mod N; lowest k with demand wins.
  always_comb begin
    rot   = {demanda_q, demanda_q} >> ({1'b0, fase_q} + 1'b1);
    sig_i = int'(fase_q) + 1;
    for (int k = N_VIAS - 1; k >= 1; k--) begin
      if (rot[k-1]) sig_i = int'(fase_q) + k;
    end
    if (sig_i >= N_VIAS) sig_i = sig_i - N_VIAS;
    siguiente = FW'(sig_i);
  end

  always_comb begin
    estado_d     = estado_q;
    fase_d       = fase_q;
    cuenta_d     = cuenta_q;
    presc_d      = presc_q;
    entra_verde  = 1'b0;
    entra_peaton = 1'b0;
    if (enable) presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) begin
      if (cuenta_q != 8'd1) begin
        cuenta_d = cuenta_q - 8'd1;
      end else begin
        unique case (estado_q)
          VERDE: begin
            if (!otras_dem && !ped_pend_q) begin
              cuenta_d = 8'(T_VERDE);
            end else begin
              estado_d = AMARILLO;
              cuenta_d = 8'(T_AMARILLO);
            end
          end
          AMARILLO: begin
            estado_d = TODO_ROJO;
            cuenta_d = 8'(T_TODO_ROJO);
          end
          TODO_ROJO: begin
            if (ped_pend_q) begin
              estado_d     = PEATON;
              cuenta_d     = 8'(T_PEATON);
              entra_peaton = 1'b1;
            end else begin
              estado_d    = VERDE;
              fase_d      = siguiente;
              cuenta_d    = 8'(T_VERDE);
              entra_verde = 1'b1;
            end
          end
          PEATON: begin
            estado_d    = VERDE;
            fase_d      = siguiente;
            cuenta_d    = 8'(T_VERDE);
            entra_verde = 1'b1;
          end
          default: estado_d = TODO_ROJO;
        endcase
      end
    end

    // Requests keep latching while frozen; a clear on phase entry beats a new set.
    demanda_d = demanda_q | sensor;
    if (entra_verde) demanda_d = demanda_d & ~(N_VIAS'(1) << fase_d);
    ped_pend_d = (ped_pend_q | (|paso)) & ~entra_peaton;

    verde_d    = (estado_d == VERDE)    ? (N_VIAS'(1) << fase_d) : '0;
    amarillo_d = (estado_d == AMARILLO) ? (N_VIAS'(1) << fase_d) : '0;
    rojo_d     = ~(verde_d | amarillo_d);
    peaton_d   = (estado_d == PEATON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= TODO_ROJO;
      fase_q     <= FW'(N_VIAS - 1);
      cuenta_q   <= 8'(T_TODO_ROJO);
      presc_q    <= '0;
      demanda_q  <= '0;
      ped_pend_q <= 1'b0;
      verde_q    <= '0;
      amarillo_q <= '0;
      rojo_q     <= '1;
      peaton_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      fase_q     <= fase_d;
      cuenta_q   <= cuenta_d;
      presc_q    <= presc_d;
      demanda_q  <= demanda_d;
      ped_pend_q <= ped_pend_d;
      verde_q    <= verde_d;
      amarillo_q <= amarillo_d;
      rojo_q     <= rojo_d;
      peaton_q   <= peaton_d;
    end
  end

  assign verde     = verde_q;
  assign amarillo  = amarillo_q;
  assign rojo      = rojo_q;
  assign peaton_ok = peaton_q;
  assign cuenta    = cuenta_q;
  assign fase      = fase_q;
endmodule
